// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-enable 7-segment display.
//   Each digit gets a slot of DIGIT_TICKS clocks. The first DEAD_TICKS clocks
//   of a slot keep every digit dark so the previous digit's pattern does not
//   ghost onto the next one. Inputs are snapshotted once per frame, at the
//   start of digit0's slot, so a frame never shows a mix of old and new values.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          1 = scanning, 0 = display dark and scan restarts at digit0
//   digits      hex nibbles, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   dp_in       decimal point per digit, 1 = lit
//   blank_in    force digit i dark (segments off, dp still honoured)
//   seg         {g,f,e,d,c,b,a}, active-high
//   dp          decimal point, active-high
//   en_n        digit enables, active-low, en_n[i] = digit i
//   frame_start one-cycle pulse in the cycle after a snapshot is taken
module seg7_scan_driver #(
    parameter int DIGIT_TICKS = 12000,
    parameter int DEAD_TICKS  = 240,
    parameter bit LZB         = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  en_n,
    output logic        frame_start
);

    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_TICKS);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   digits_sh;
    logic [3:0]    dp_sh;
    logic [3:0]    blank_sh;

    logic          snap;
    logic [15:0]   digits_cur;
    logic [3:0]    dp_cur;
    logic [3:0]    blank_cur;
    logic [3:0]    lz_blank;
    logic [3:0]    nib;
    logic          show;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    en_n_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        snap = en && (idx == 2'd0) && (cnt == '0);

        // Output registers load in the same edge as the snapshot, so they
        // look through to the incoming values in that cycle. This keeps the
        // first SHOW cycle correct even when DEAD_TICKS is 0.
        digits_cur = snap ? digits   : digits_sh;
        dp_cur     = snap ? dp_in    : dp_sh;
        blank_cur  = snap ? blank_in : blank_sh;

        // Leading-zero suppression: a digit is blank when it and every digit
        // to its left are zero. digit0 is always shown.
        lz_blank = 4'b0000;
        if (LZB) begin
            lz_blank[3] = (digits_cur[15:12] == 4'h0);
            lz_blank[2] = lz_blank[3] && (digits_cur[11:8] == 4'h0);
            lz_blank[1] = lz_blank[2] && (digits_cur[7:4] == 4'h0);
        end

        case (idx)
            2'd0:    nib = digits_cur[3:0];
            2'd1:    nib = digits_cur[7:4];
            2'd2:    nib = digits_cur[11:8];
            default: nib = digits_cur[15:12];
        endcase

        show     = en && (cnt >= DEAD_CNT);
        seg_nxt  = 7'h00;
        dp_nxt   = 1'b0;
        en_n_nxt = 4'b1111;
        if (show) begin
            en_n_nxt[idx] = 1'b0;
            dp_nxt        = dp_cur[idx];
            if (!(blank_cur[idx] || lz_blank[idx])) begin
                seg_nxt = decode(nib);
            end
        end
    end

    // Slot counter and digit index; en=0 parks the scan at digit0, cnt=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (!en) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow registers; held while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_sh <= 16'h0000;
            dp_sh     <= 4'h0;
            blank_sh  <= 4'h0;
        end else if (snap) begin
            digits_sh <= digits;
            dp_sh     <= dp_in;
            blank_sh  <= blank_in;
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= 7'h00;
            dp          <= 1'b0;
            en_n        <= 4'b1111;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            en_n        <= en_n_nxt;
            frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Bench for seg7_scan_driver with DIGIT_TICKS=8, DEAD_TICKS=2, LZB=1.
//   A behavioural model counts enabled cycles since the scan restarted and
//   derives slot, phase and shadow contents from that count. Outputs are
//   compared against it on every falling edge; directed frames add literal
//   expectations taken straight from the display tables.
module tb_seg7_scan_driver;

    localparam int DT    = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  en_n;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    seg7_scan_driver #(
        .DIGIT_TICKS(DT),
        .DEAD_TICKS (DEAD),
        .LZB        (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg        (seg),
        .dp         (dp),
        .en_n       (en_n),
        .frame_start(frame_start)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          pos = 0;          // enabled cycles since scan restart, mod FRAME
    logic [15:0] m_dig = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_bl = 4'h0;
    logic [6:0]  e_seg = 7'h00;
    logic        e_dp = 1'b0;
    logic [3:0]  e_en_n = 4'hF;
    logic        e_fs = 1'b0;

    // {frame_start, en_n, seg, dp} for one cycle of the scan.
    function automatic logic [12:0] model_out(input logic e, input int p,
                                              input logic [15:0] d, input logic [3:0] dpm,
                                              input logic [3:0] bl);
        int slot, off;
        logic [3:0] nn;
        logic       blank;
        logic [3:0] ee;
        logic [6:0] ss;
        logic       pp;
        ee = 4'hF; ss = 7'h00; pp = 1'b0;
        if (e) begin
            slot = (p / DT) % 4;
            off  = p % DT;
            if (off >= DEAD) begin
                ee[slot] = 1'b0;
                nn    = 4'((d >> (4 * slot)) & 16'hF);
                // leading zero: this digit and everything left of it is zero
                blank = bl[slot] || (slot > 0 && (d >> (4 * slot)) == 16'h0);
                ss    = blank ? 7'h00 : seg_tab[nn];
                pp    = dpm[slot];
            end
        end
        return {(e && p == 0), ee, ss, pp};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= 0;
            m_dig  <= 16'h0;
            m_dp   <= 4'h0;
            m_bl   <= 4'h0;
            e_seg  <= 7'h00;
            e_dp   <= 1'b0;
            e_en_n <= 4'hF;
            e_fs   <= 1'b0;
        end else begin
            if (!en) begin
                pos <= 0;
                {e_fs, e_en_n, e_seg, e_dp} <= model_out(1'b0, 0, m_dig, m_dp, m_bl);
            end else if (pos == 0) begin
                m_dig <= digits;
                m_dp  <= dp_in;
                m_bl  <= blank_in;
                {e_fs, e_en_n, e_seg, e_dp} <= model_out(1'b1, 0, digits, dp_in, blank_in);
                pos <= 1;
            end else begin
                {e_fs, e_en_n, e_seg, e_dp} <= model_out(1'b1, pos, m_dig, m_dp, m_bl);
                pos <= (pos + 1) % FRAME;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            chk("seg", {9'h0, seg}, {9'h0, e_seg});
            chk("dp", {15'h0, dp}, {15'h0, e_dp});
            chk("en_n", {12'h0, en_n}, {12'h0, e_en_n});
            chk("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
            chk("one_enable", {15'h0, ($countones(~en_n) <= 1)}, 16'h1);
            chk("dark_when_off", {15'h0, (en_n != 4'hF) || (seg == 7'h00 && dp == 1'b0)}, 16'h1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        en = 1'b0;
        @(negedge clk);
        digits = d; dp_in = p; blank_in = b;
        en = 1'b1;
    endtask

    // Runs one full frame from a clean start and checks every SHOW slot.
    // exp_seg = {d3, d2, d1, d0}.
    task automatic frame_check(input string name, input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] b, input logic [27:0] exp_seg,
                               input logic [3:0] exp_dp);
        logic [3:0] ee;
        start_frame(d, p, b);
        @(negedge clk);
        chk({name, "_fs"}, {15'h0, frame_start}, 16'h1);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            ee = 4'hF;
            ee[s] = 1'b0;
            chk({name, "_en_n"}, {12'h0, en_n}, {12'h0, ee});
            chk({name, "_seg"}, {9'h0, seg}, {9'h0, exp_seg[7*s +: 7]});
            chk({name, "_dp"}, {15'h0, dp}, {15'h0, exp_dp[s]});
            repeat (DT) @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;
        chk("reset_en_n", {12'h0, en_n}, 16'h000F);
        chk("reset_seg", {9'h0, seg}, 16'h0000);

        // basic frame, dead phase of digit0
        start_frame(16'h1234, 4'h0, 4'h0);
        @(negedge clk);
        chk("t1_fs", {15'h0, frame_start}, 16'h1);
        chk("t1_dead0", {12'h0, en_n}, 16'h000F);
        @(negedge clk);
        chk("t1_dead1", {12'h0, en_n}, 16'h000F);
        chk("t1_fs_once", {15'h0, frame_start}, 16'h0);

        frame_check("t1", 16'h1234, 4'h0, 4'h0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0);
        frame_check("t2a", 16'h0070, 4'h0, 4'h0, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'h0);
        frame_check("t2b", 16'h0000, 4'h0, 4'h0, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0);
        frame_check("t4", 16'h8888, 4'b0100, 4'b0100, {7'h7F, 7'h00, 7'h7F, 7'h7F}, 4'b0100);

        // mid-frame input change is invisible until the next snapshot
        start_frame(16'h1234, 4'h0, 4'h0);
        repeat (19) @(negedge clk);
        chk("t3_d2_old", {9'h0, seg}, 16'h005B);
        digits = 16'h5678;
        repeat (8) @(negedge clk);
        chk("t3_d3_old", {9'h0, seg}, 16'h0006);
        repeat (6) @(negedge clk);
        chk("t3_fs", {15'h0, frame_start}, 16'h1);
        repeat (2) @(negedge clk);
        chk("t3_d0_new", {9'h0, seg}, 16'h007F);
        repeat (8) @(negedge clk);
        chk("t3_d1_new", {9'h0, seg}, 16'h0007);

        // en dropped during digit1 SHOW
        start_frame(16'h1234, 4'h0, 4'h0);
        repeat (11) @(negedge clk);
        chk("t5_show", {12'h0, en_n}, 16'h000D);
        en = 1'b0;
        @(negedge clk);
        chk("t5_off_en_n", {12'h0, en_n}, 16'h000F);
        chk("t5_off_seg", {9'h0, seg}, 16'h0000);
        en = 1'b1;
        @(negedge clk);
        chk("t5_fs", {15'h0, frame_start}, 16'h1);
        chk("t5_dead", {12'h0, en_n}, 16'h000F);
        repeat (2) @(negedge clk);
        chk("t5_restart", {12'h0, en_n}, 16'h000E);
        chk("t5_restart_seg", {9'h0, seg}, 16'h0066);

        // async reset mid-SHOW
        start_frame(16'h1234, 4'h0, 4'h0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_en_n", {12'h0, en_n}, 16'h000F);
        chk("t6_async_seg", {9'h0, seg}, 16'h0000);
        @(negedge clk);
        en = 1'b0;
        digits = 16'h0000;
        rst_n = 1'b1;
        frame_check("t6", 16'h0000, 4'h0, 4'h0, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) digits = 16'($urandom());
            if ($urandom_range(0, 19) == 0) digits = {12'h0, 4'($urandom())};
            if ($urandom_range(0, 29) == 0) dp_in = 4'($urandom());
            if ($urandom_range(0, 29) == 0) blank_in = 4'($urandom());
            en = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit common-enable 7-segment display on the board.
- Sits directly upstream of the segment/enable pins (DS_A..DS_G, DS_DP, DS_EN1..4). Replaces static all-digits-on drive with per-digit scanning.
- Accepts four hex nibbles plus decimal-point and blank masks from any producer (counter, clock, debug logic).
- Snapshots inputs once per frame, so values never tear mid-frame.

Parameters:
DIGIT_TICKS, 12000, clk cycles per digit slot (48 MHz / 12000 = 4 kHz slot, 1 kHz frame)
DEAD_TICKS, 240, cycles at start of each slot with all digits off (ghosting guard); must be < DIGIT_TICKS
LZB, 1, 1 = suppress leading zeros on digits 3..1

Ports:
clk  in  1  system clock, 48 MHz
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = scanning; 0 = display dark, scan restarts
digits  in  16  hex values; [3:0] = digit0 (rightmost) .. [15:12] = digit3 (leftmost)
dp_in  in  4  decimal point per digit, bit i = digit i, 1 = lit
blank_in  in  4  force digit i dark (segments off; dp still honoured)
seg  out  7  {g,f,e,d,c,b,a}, active-high
dp  out  1  decimal point, active-high
en_n  out  4  digit enables, active-low; en_n[i] = digit i (digit3 = DS_EN1, digit0 = DS_EN4)
frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async, rst_n=0): seg=0, dp=0, en_n=4'b1111, frame_start=0, cnt=0, idx=0, shadow regs=0.
- Counters:
  - cnt runs 0..DIGIT_TICKS-1. At wrap, idx advances 0→1→2→3→0.
  - Width of cnt = clog2(DIGIT_TICKS).
- Snapshot: in any cycle with en=1, idx=0 and cnt=0, latch digits/dp_in/blank_in into shadow regs. frame_start=1 on the following cycle only.
- Slot phases, per cnt:
  - DEAD, cnt < DEAD_TICKS: en_n=1111, seg=0, dp=0.
  - SHOW, cnt ≥ DEAD_TICKS: en_n has only bit idx low; seg/dp for shadow digit idx.
- Latency: outputs are registered, one cycle after the counter state that selects them. No combinational path from inputs to pins.
- Decode (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blanking (LZB=1):
  - digit3 blanked if d3==0
  - digit2 blanked if d3==d2==0
  - digit1 blanked if d3..d1==0
  - digit0 never blanked by LZB
- blank_in[i]=1 blanks digit i regardless of LZB.
- A blanked digit gives seg=0 and dp=dp_sh[i]. Its enable is still driven in SHOW.
- en=0: next cycle cnt=0, idx=0, en_n=1111, seg=0, dp=0. Shadow regs are held.
- en 0→1: the first en=1 cycle snapshots (cnt=0, idx=0). The frame starts cleanly with digit0 DEAD phase.
- Input changes mid-frame have no visible effect until the next snapshot.
- Reset asserted mid-slot: outputs go dark immediately (async). After release, the scan restarts at digit0.
- Never more than one en_n bit low in any cycle.
- Never segment activity while en_n=1111.

Test Plan:
(All use DIGIT_TICKS=8, DEAD_TICKS=2.)
1. Reset then en=1, digits=16'h1234, dp_in=0, LZB=1:
   - frame_start pulses once per 32 cycles.
   - Digit0 slot: 2 cycles en_n=1111/seg=00, then 6 cycles en_n=1110/seg=66.
   - Following slots: en_n=1101/4F, then 1011/5B, then 0111/06.
2. digits=16'h0070, LZB=1:
   - digit3 and digit2 show seg=00 with enable active.
   - digit1 shows 07. digit0 shows 3F.
   - digits=0000 shows only digit0=3F.
3. Change digits from 1234 to 5678 while idx=2:
   - digits 2 and 3 still show 2 and 1 in that frame.
   - The next frame shows 8,7,6,5 (7F,07,7D,6D) after frame_start.
4. dp_in=4'b0100, blank_in=4'b0100, digits=16'h8888:
   - digit2 SHOW gives seg=00, dp=1.
   - Other digits give seg=7F, dp=0.
5. en dropped to 0 during digit1 SHOW:
   - Next cycle en_n=1111, seg=00.
   - Re-enable gives frame_start after 1 cycle and restart at digit0 DEAD.
6. rst_n pulsed low mid-SHOW:
   - en_n=1111 and seg=00 in the same cycle, without waiting for a clk edge.
   - After release, scan restarts at idx=0 with shadow=0000; LZB gives digit0=3F.
   - Every cycle is checked for at most one en_n bit low.
